// File: rtl/ssd_pkg.sv
// Shared seven-segment encodings for the display scanner.
// Patterns are active-low {a,b,c,d,e,f,g}, with a in the MSB.
package ssd_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    case (nibble)
      4'h0:    hex_to_seg = SEG_0;
      4'h1:    hex_to_seg = SEG_1;
      4'h2:    hex_to_seg = SEG_2;
      4'h3:    hex_to_seg = SEG_3;
      4'h4:    hex_to_seg = SEG_4;
      4'h5:    hex_to_seg = SEG_5;
      4'h6:    hex_to_seg = SEG_6;
      4'h7:    hex_to_seg = SEG_7;
      4'h8:    hex_to_seg = SEG_8;
      4'h9:    hex_to_seg = SEG_9;
      4'hA:    hex_to_seg = SEG_A;
      4'hB:    hex_to_seg = SEG_B;
      4'hC:    hex_to_seg = SEG_C;
      4'hD:    hex_to_seg = SEG_D;
      4'hE:    hex_to_seg = SEG_E;
      4'hF:    hex_to_seg = SEG_F;
      default: hex_to_seg = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex nibble to active-low a..g segment pattern.
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/ssd_scan_mux.sv
// N-digit common-anode seven-segment scanner with guard time, PWM dimming,
// leading-zero blanking and a frame-synchronous shadow copy of the inputs.
module ssd_scan_mux
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16,
  parameter int DUTY_BITS   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  input  logic [DUTY_BITS-1:0]    brightness,
  output logic [7:0]              ssd_cathode,
  output logic [NUM_DIGITS-1:0]   ssd_anode,
  output logic                    frame_tick
);

  localparam int PRE_W  = $clog2(REFRESH_DIV);
  localparam int SLOT_W = $clog2(NUM_DIGITS);

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0]  GUARD_END = PRE_W'(GUARD);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]                 prescaler;
  logic [SLOT_W-1:0]                slot;
  logic [DUTY_BITS-1:0]             pwm_cnt;

  logic [NUM_DIGITS-1:0][3:0]       sh_nib;
  logic [NUM_DIGITS-1:0]            sh_dp;
  logic [NUM_DIGITS-1:0]            sh_en;
  logic                             sh_blank_lz;

  logic                             capture;
  logic                             pwm_on;
  logic                             digit_active;
  logic [NUM_DIGITS-1:0]            lz_blank;
  logic [NUM_DIGITS-1:0]            anode_sel;
  logic [6:0]                       seg;

  assign capture = (slot == '0) && (prescaler == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      slot      <= '0;
      pwm_cnt   <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (prescaler == PRE_LAST) begin
        prescaler <= '0;
        slot      <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  // Inputs are only sampled at frame start so a frame never mixes old and new values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_nib      <= '0;
      sh_dp       <= '0;
      sh_en       <= '0;
      sh_blank_lz <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      frame_tick <= capture;
      if (capture) begin
        sh_nib      <= digits;
        sh_dp       <= dp;
        sh_en       <= digit_en;
        sh_blank_lz <= blank_lz;
      end
    end
  end

  // Walk down from the most significant digit; blanking stops at the first non-zero.
  always_comb begin
    logic zero_above;
    lz_blank   = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above  = zero_above & (sh_nib[i] == 4'd0);
      lz_blank[i] = sh_blank_lz & zero_above;
    end
  end

  ssd_hex_decoder u_hex_decoder (
    .nibble (sh_nib[slot]),
    .seg    (seg)
  );

  assign pwm_on = (&brightness) || (pwm_cnt < brightness);

  assign digit_active = (prescaler >= GUARD_END) && pwm_on &&
                        sh_en[slot] && !lz_blank[slot];

  always_comb begin
    anode_sel       = '1;
    anode_sel[slot] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ssd_anode   <= '1;
      ssd_cathode <= 8'hFF;
    end else if (digit_active) begin
      ssd_anode   <= anode_sel;
      ssd_cathode <= {seg, ~sh_dp[slot]};
    end else begin
      ssd_anode   <= '1;
      ssd_cathode <= 8'hFF;
    end
  end

endmodule
